// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester round-robin arbiter feeding an 8N1 UART
// serializer. A granted requester holds the line for a whole packet (until a
// byte flagged last has been sent) or until it stalls past LOCK_TIMEOUT idle
// cycles. The tx output is registered so the board pin never glitches.
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic [1:0] grant
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] TO_MAX   = 16'(LOCK_TIMEOUT - 1);

  // Registered state
  state_t      r_state;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_last;
  logic        r_lock;
  logic        r_owner;   // 0 = req0, 1 = req1 (meaningful while locked)
  logic        r_ptr;     // side that wins when both request with no lock
  logic [1:0]  r_grant;
  logic [15:0] r_to_cnt;
  logic        r_tx;

  // Next-state values
  state_t      w_state_next;
  logic [15:0] w_baud_cnt_next;
  logic [2:0]  w_bit_idx_next;
  logic [7:0]  w_shift_next;
  logic        w_last_next;
  logic        w_lock_next;
  logic        w_owner_next;
  logic        w_ptr_next;
  logic [1:0]  w_grant_next;
  logic [15:0] w_to_cnt_next;
  logic        w_tx_next;

  // Arbitration wires
  logic        w_owner_valid;
  logic        w_sel;
  logic        w_sel_valid;
  logic        w_idle;
  logic        w_hs;
  logic        w_baud_done;

  // Pick the eligible requester: the owner while locked, otherwise a lone
  // requester or the pointer side when both are asking.
  always_comb begin
    w_owner_valid = r_owner ? req1_valid : req0_valid;
    w_sel         = 1'b0;
    w_sel_valid   = 1'b0;
    if (r_lock) begin
      w_sel       = r_owner;
      w_sel_valid = w_owner_valid;
    end else if (req0_valid && req1_valid) begin
      w_sel       = r_ptr;
      w_sel_valid = 1'b1;
    end else begin
      w_sel       = req1_valid;
      w_sel_valid = req0_valid | req1_valid;
    end
  end

  // Ready is held low while reset is asserted even though the state reads IDLE.
  assign w_idle      = (r_state == IDLE) && !reset;
  assign w_hs        = w_idle && w_sel_valid;
  assign req0_ready  = w_hs && !w_sel;
  assign req1_ready  = w_hs && w_sel;
  assign w_baud_done = (r_baud_cnt == BAUD_MAX);

  assign tx    = r_tx;
  assign busy  = (r_state != IDLE);
  assign grant = r_grant;

  // Next-state logic: handshake and lock timeout in IDLE, bit timing elsewhere.
  always_comb begin
    w_state_next    = r_state;
    w_baud_cnt_next = r_baud_cnt;
    w_bit_idx_next  = r_bit_idx;
    w_shift_next    = r_shift;
    w_last_next     = r_last;
    w_lock_next     = r_lock;
    w_owner_next    = r_owner;
    w_ptr_next      = r_ptr;
    w_grant_next    = r_grant;
    w_to_cnt_next   = r_to_cnt;

    case (r_state)
      IDLE: begin
        if (w_hs) begin
          // A handshake always beats a timeout landing on the same cycle.
          w_shift_next    = w_sel ? req1_data : req0_data;
          w_last_next     = w_sel ? req1_last : req0_last;
          w_owner_next    = w_sel;
          w_grant_next    = w_sel ? 2'b10 : 2'b01;
          w_lock_next     = 1'b1;
          w_to_cnt_next   = 16'd0;
          w_baud_cnt_next = 16'd0;
          w_state_next    = START;
        end else if (r_lock && !w_owner_valid) begin
          if (r_to_cnt == TO_MAX) begin
            // Stalled owner loses the lock; grant keeps the last owner.
            w_lock_next   = 1'b0;
            w_ptr_next    = ~r_owner;
            w_to_cnt_next = 16'd0;
          end else begin
            w_to_cnt_next = r_to_cnt + 16'd1;
          end
        end
      end
      START: begin
        if (w_baud_done) begin
          w_baud_cnt_next = 16'd0;
          w_bit_idx_next  = 3'd0;
          w_state_next    = DATA;
        end else begin
          w_baud_cnt_next = r_baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (w_baud_done) begin
          w_baud_cnt_next = 16'd0;
          if (r_bit_idx == 3'd7) begin
            w_state_next = STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_shift_next   = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_cnt_next = r_baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (w_baud_done) begin
          w_baud_cnt_next = 16'd0;
          w_state_next    = IDLE;
          if (r_last) begin
            // Packet complete: release and hand priority to the other side.
            w_lock_next   = 1'b0;
            w_ptr_next    = ~r_owner;
            w_to_cnt_next = 16'd0;
          end
        end else begin
          w_baud_cnt_next = r_baud_cnt + 16'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Line level for the coming cycle, derived from where the FSM is heading.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  // State register; reset aborts any frame and idles the line at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_baud_cnt <= 16'd0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
      r_last     <= 1'b0;
      r_lock     <= 1'b0;
      r_owner    <= 1'b0;
      r_ptr      <= 1'b0;
      r_grant    <= 2'b00;
      r_to_cnt   <= 16'd0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shift    <= w_shift_next;
      r_last     <= w_last_next;
      r_lock     <= w_lock_next;
      r_owner    <= w_owner_next;
      r_ptr      <= w_ptr_next;
      r_grant    <= w_grant_next;
      r_to_cnt   <= w_to_cnt_next;
      r_tx       <= w_tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed steps with random payloads, plus a
// randomized packet phase whose expected service order comes from a
// packet-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int CPB  = 4;
  localparam int TO   = 8;
  localparam int FLEN = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_last, req1_valid, req1_last;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready, tx, busy;
  logic [1:0] grant;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       side;
    logic       last;
    logic [7:0] data;
  } ent_t;

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .LOCK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx(tx), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0; req0_last = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_last = 1'b0; req1_data = 8'h00;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  // Wait for a ready pulse; it must come from 'who' exactly exp_wait cycles on.
  task automatic expect_grant(input string tag, input int who, input int exp_wait);
    bit found;
    found = 1'b0;
    for (int i = 0; i <= exp_wait + 20; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk($sformatf("%s owner", tag), {62'd0, req1_ready, req0_ready}, (who == 0) ? 64'd1 : 64'd2);
        chk($sformatf("%s wait", tag), 64'(i), 64'(exp_wait));
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk($sformatf("%s granted", tag), {63'd0, found}, 64'd1);
  endtask

  // Called just after the handshake edge: records the whole frame, then the
  // first idle cycle, and compares against the 8N1 waveform of byte b.
  task automatic capture_frame(input string tag, input logic [7:0] b, input logic [1:0] g);
    logic [FLEN-1:0] got_tx, exp_tx, got_busy;
    logic rdy_seen;
    int   k;
    rdy_seen = 1'b0;
    chk($sformatf("%s grant", tag), {62'd0, grant}, {62'd0, g});
    for (int c = 0; c < FLEN; c++) begin
      if (c > 0) cyc();
      got_tx[c]   = tx;
      got_busy[c] = busy;
      rdy_seen    = rdy_seen | req0_ready | req1_ready;
      k = c / CPB;
      exp_tx[c] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
    end
    chk($sformatf("%s tx", tag), 64'(got_tx), 64'(exp_tx));
    chk($sformatf("%s busy", tag), 64'(got_busy), {(64-FLEN)'(0), {FLEN{1'b1}}});
    chk($sformatf("%s ready during frame", tag), {63'd0, rdy_seen}, 64'd0);
    cyc();
    chk($sformatf("%s gap busy", tag), {63'd0, busy}, 64'd0);
    chk($sformatf("%s gap tx", tag), {63'd0, tx}, 64'd1);
    $display("frame %s: byte=%02h grant=%b", tag, b, g);
  endtask

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  ent_t       exp_q[$];

  task automatic drive_heads();
    req0_valid = (q0.size() > 0);
    if (q0.size() > 0) {req0_last, req0_data} = q0[0];
    req1_valid = (q1.size() > 0);
    if (q1.size() > 0) {req1_last, req1_data} = q1[0];
  endtask

  initial begin
    logic [7:0] b, b1;
    logic [7:0] bytes3[3];
    logic       rdy;
    int         np0, np1, side, len;
    int         lens0[4];
    int         lens1[4];
    ent_t       e;

    // ---------------- reset values ----------------
    reset = 1'b1;
    req0_valid = 1'b0; req0_last = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_last = 1'b0; req1_data = 8'h00;
    cyc();
    cyc();
    chk("reset tx", {63'd0, tx}, 64'd1);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    chk("reset grant", {62'd0, grant}, 64'd0);
    reset = 1'b0;
    cyc();

    // ---------------- single byte 0xA5 ----------------
    req0_valid = 1'b1; req0_data = 8'hA5; req0_last = 1'b1;
    expect_grant("single", 0, 0);
    cyc();
    req0_valid = 1'b0; req0_data = 8'h3C;   // changing data after handshake has no effect
    capture_frame("single", 8'hA5, 2'b01);
    b = 8'($urandom);
    req1_valid = 1'b1; req1_data = b; req1_last = 1'b1;
    expect_grant("unlocked", 1, 0);
    cyc();
    req1_valid = 1'b0;
    capture_frame("unlocked", b, 2'b10);

    // ---------------- reset mid-frame ----------------
    req0_valid = 1'b1; req0_data = 8'($urandom); req0_last = 1'b1;
    expect_grant("midrst", 0, 0);
    cyc();
    cyc();
    chk("midrst start tx", {63'd0, tx}, 64'd0);
    chk("midrst start busy", {63'd0, busy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst async tx", {63'd0, tx}, 64'd1);
    chk("midrst async busy", {63'd0, busy}, 64'd0);
    chk("midrst async ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    chk("midrst async grant", {62'd0, grant}, 64'd0);
    cyc();
    req0_data = 8'h5A;
    reset = 1'b0;
    expect_grant("post-reset", 0, 0);
    cyc();
    req0_valid = 1'b0;
    capture_frame("post-reset", 8'h5A, 2'b01);

    // ---------------- round-robin from reset ----------------
    do_reset();
    req0_valid = 1'b1; req0_last = 1'b1; req0_data = 8'($urandom);
    req1_valid = 1'b1; req1_last = 1'b1; req1_data = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      expect_grant($sformatf("rr%0d", i), i % 2, 0);
      cyc();
      if (i % 2 == 0) begin b = req0_data; req0_data = 8'($urandom); end
      else            begin b = req1_data; req1_data = 8'($urandom); end
      capture_frame($sformatf("rr%0d", i), b, (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // ---------------- packet lock ----------------
    do_reset();
    b1 = 8'($urandom);
    req1_valid = 1'b1; req1_data = b1; req1_last = 1'b1;
    for (int i = 0; i < 3; i++) bytes3[i] = 8'($urandom);
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_data = bytes3[i];
      req0_last = (i == 2);
      expect_grant($sformatf("lock%0d", i), 0, 0);
      cyc();
      if (i == 2) req0_valid = 1'b0;
      capture_frame($sformatf("lock%0d", i), bytes3[i], 2'b01);
    end
    expect_grant("lock other", 1, 0);
    cyc();
    req1_valid = 1'b0;
    capture_frame("lock other", b1, 2'b10);

    // ---------------- lock timeout ----------------
    do_reset();
    b = 8'($urandom); b1 = 8'($urandom);
    req0_valid = 1'b1; req0_data = b;  req0_last = 1'b0;
    req1_valid = 1'b1; req1_data = b1; req1_last = 1'b1;
    expect_grant("to owner", 0, 0);
    cyc();
    req0_valid = 1'b0;
    capture_frame("to owner", b, 2'b01);
    expect_grant("to expire", 1, TO);
    chk("to grant kept", {62'd0, grant}, 64'd1);
    cyc();
    req1_valid = 1'b0;
    capture_frame("to expire", b1, 2'b10);

    // ---------------- owner returns on the last idle cycle ----------------
    do_reset();
    b = 8'($urandom); b1 = 8'($urandom);
    req0_valid = 1'b1; req0_data = b;  req0_last = 1'b0;
    req1_valid = 1'b1; req1_data = b1; req1_last = 1'b1;
    expect_grant("tov owner", 0, 0);
    cyc();
    req0_valid = 1'b0;
    capture_frame("tov owner", b, 2'b01);
    rdy = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      #1;
      rdy = rdy | req0_ready | req1_ready;
      cyc();
    end
    chk("tov held off", {63'd0, rdy}, 64'd0);
    b = 8'($urandom);
    req0_valid = 1'b1; req0_data = b; req0_last = 1'b1;
    expect_grant("tov return", 0, 0);
    cyc();
    req0_valid = 1'b0;
    capture_frame("tov return", b, 2'b01);
    expect_grant("tov other", 1, 0);
    cyc();
    req1_valid = 1'b0;
    capture_frame("tov other", b1, 2'b10);

    // ---------------- back-to-back same owner ----------------
    do_reset();
    bytes3[0] = 8'h00; bytes3[1] = 8'hFF; bytes3[2] = 8'h81;
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req1_data = bytes3[i];
      req1_last = (i == 2);
      expect_grant($sformatf("b2b%0d", i), 1, 0);
      cyc();
      if (i == 2) req1_valid = 1'b0;
      capture_frame($sformatf("b2b%0d", i), bytes3[i], 2'b10);
    end

    // ---------------- randomized packets ----------------
    // Model: each side holds a list of packets; packets are served whole, and
    // after each packet service passes to the other side if it has work.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      lens0[p] = int'($urandom_range(1, 3));
      lens1[p] = int'($urandom_range(1, 3));
      for (int j = 0; j < lens0[p]; j++) q0.push_back({(j == lens0[p] - 1), 8'($urandom)});
      for (int j = 0; j < lens1[p]; j++) q1.push_back({(j == lens1[p] - 1), 8'($urandom)});
    end
    np0 = 0; np1 = 0; side = 0;
    begin
      int off0, off1;
      off0 = 0; off1 = 0;
      while (np0 < 4 || np1 < 4) begin
        len = (side == 0) ? lens0[np0] : lens1[np1];
        for (int j = 0; j < len; j++) begin
          e.side = side[0];
          if (side == 0) {e.last, e.data} = q0[off0 + j];
          else           {e.last, e.data} = q1[off1 + j];
          exp_q.push_back(e);
        end
        if (side == 0) begin np0++; off0 += len; end
        else           begin np1++; off1 += len; end
        if ((side == 0 && np1 < 4) || (side == 1 && np0 < 4)) side = 1 - side;
      end
    end
    drive_heads();
    for (int n = 0; n < exp_q.size(); n++) begin
      e = exp_q[n];
      expect_grant($sformatf("rnd%0d", n), int'(e.side), 0);
      cyc();
      if (e.side) void'(q1.pop_front());
      else        void'(q0.pop_front());
      drive_heads();
      capture_frame($sformatf("rnd%0d", n), e.data, e.side ? 2'b10 : 2'b01);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmit line between two byte requesters, e.g. the RISC-V multicycle core's UART port (req0) and a debug/status reporter (req1). Arbitration is round-robin at packet granularity: a granted requester keeps the line until it sends a byte flagged last, or until it stalls past a timeout. The block contains the 8N1 serializer, so tx drives the board pin directly.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
LOCK_TIMEOUT, 1024, idle cycles a locked owner may leave valid low before its lock is dropped; legal range 1..65535.

Ports:
clk  input  1  system clock (PLL output)
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has a byte
req0_data  input  8  requester 0 byte
req0_last  input  1  byte ends requester 0's packet
req0_ready  output  1  byte accepted this cycle when high with req0_valid
req1_valid  input  1  requester 1 has a byte
req1_data  input  8  requester 1 byte
req1_last  input  1  byte ends requester 1's packet
req1_ready  output  1  byte accepted this cycle when high with req1_valid
tx  output  1  UART serial out, idle high
busy  output  1  frame in progress (state != IDLE)
grant  output  2  one-hot current/last owner; 00 = none

Behaviour:
- Reset is asynchronous, active-high. On reset: tx=1, busy=0, req0_ready=0, req1_ready=0, grant=00, lock cleared, round-robin pointer favours req0, all counters 0. Reset during a frame aborts it and tx goes to 1 immediately. No partial byte is resumed.
- FSM states: IDLE, START, DATA, STOP.
- Selection happens only in IDLE and is combinational:
  - Lock set: only the owner is eligible.
  - Lock clear: a lone valid requester wins. If both are valid, the pointer side wins.
- readyN = (state==IDLE) && selected==N && reqN_valid. At most one ready is high in any cycle.
- Handshake is valid&&ready at a clk edge. On that edge:
  - data is latched into the shift register and last into a flag;
  - grant is set to the winner and lock is set;
  - state goes to START.
- Data may change after the handshake without effect.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: 8 bits LSB first, CLKS_PER_BIT cycles each. A 3-bit index counts the bits, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame timing: tx falls on the edge after the handshake. The frame is exactly 10*CLKS_PER_BIT cycles. The earliest next handshake is the first IDLE cycle, so the minimum inter-frame gap is 1 clk (tx high).
- End of frame with the last flag set: lock clears and the pointer moves to the other requester. Without the last flag, lock stays and grant is unchanged.
- Lock timeout: in IDLE with lock set and owner valid low, a counter increments each cycle. The counter resets on any owner handshake or when lock clears. When it reaches LOCK_TIMEOUT, on that edge:
  - lock clears;
  - the pointer moves to the other requester;
  - grant stays at the last owner value (informational).
- Non-owner requests while locked are held off (ready=0) with no loss; valid must stay asserted by the requester.
- Simultaneous events:
  - Lock release and the other requester's valid in the same IDLE cycle: release takes effect on that edge, and the other requester may be granted from the next cycle.
  - A timeout and an owner valid on the same cycle: the handshake wins and the counter is reset.
- The baud counter is wide enough for CLKS_PER_BIT-1 and reloads at every bit boundary. There is no drift across bits.
- busy = 1 in START, DATA and STOP; 0 in IDLE.

Test Plan:
(Bench parameters: CLKS_PER_BIT=4, LOCK_TIMEOUT=8.)
- Reset mid-frame: assert reset while tx=0 in START -> tx=1, busy=0, ready=00, grant=00 asynchronously; after release, a req0 byte 0x5A produces a full frame from its start bit.
- Single byte: req0 sends 0xA5 with last=1 -> tx pattern over 40 cycles is 0,1,0,1,0,0,1,0,1,1 (4 clks per bit, start bit first, starting the edge after the handshake); busy high exactly 40 cycles; grant=01; lock clear afterwards.
- Round-robin: both valid from reset, each sends a 1-byte packet with last=1, continuously -> serviced order 0,1,0,1; each gap between frames is 1 clk.
- Packet lock: req0 sends 3 bytes (last on the 3rd) while req1 is valid throughout -> req1_ready stays 0 until req0's 3rd frame ends; req1 is accepted in the first IDLE cycle after it.
- Timeout: req0 sends 1 byte with last=0, then drops valid; req1 is valid -> after 8 IDLE cycles the lock drops and req1_ready pulses on the 9th cycle. A variant where req0 re-asserts valid on the 8th cycle -> req0 is served, not req1.
- Back-to-back same owner: req1 streams 0x00, 0xFF, 0x81 (last on 0x81) -> three frames, each 40 cycles, with 1-clk gaps; bit order is verified LSB first.
